client_req_arbiter: RTL and testbench

- Parametrised N-client request arbiter that sits behind the per-client request bus.
- Each client drives one bit of a shared request vector. The arbiter returns a registered one-hot grant, the encoded owner id and a preemption pulse.
- Supports fixed-priority and round-robin modes, a per-client mask, and a bounded hold time so that one client cannot starve the others.

---
 rtl/client_req_arbiter_pkg.sv | 14 +
 rtl/client_req_arbiter_pick.sv | 42 ++++
 rtl/client_req_arbiter.sv | 129 ++++++++++++
 tb/tb_client_req_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/client_req_arbiter_pkg.sv
// Shared types and helpers for the client request arbiter.
// Holds the mode/state enums and the index-width helper.
package arb_pkg;

    typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;

    typedef enum logic {ST_IDLE, ST_GRANT} arb_state_e;

    // Width needed to encode n values, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/client_req_arbiter_pick.sv
// Combinational wrapping priority search: first set bit of vec_i at or
// above start_i, wrapping round to bit 0 when none is found above.
module arb_pick #(
    parameter int NUM_CLIENTS = 8,
    parameter int ID_W        = 3
) (
    input  logic [NUM_CLIENTS-1:0] vec_i,
    input  logic [ID_W-1:0]        start_i,
    output logic                   found_o,
    output logic [NUM_CLIENTS-1:0] onehot_o,
    output logic [ID_W-1:0]        idx_o
);

    logic [NUM_CLIENTS-1:0]           upper_mask;
    logic [NUM_CLIENTS-1:0]           upper;
    logic [NUM_CLIENTS-1:0]           sel;
    logic [ID_W-1:0][NUM_CLIENTS-1:0] bit_sel;

    genvar gi, gb;

    generate
        for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_upper
            assign upper_mask[gi] = (gi >= int'(start_i));
        end
    endgenerate

    assign upper    = vec_i & upper_mask;
    assign sel      = (|upper) ? upper : vec_i;
    // Isolate the lowest set bit of the selected half.
    assign onehot_o = sel & (~sel + NUM_CLIENTS'(1));
    assign found_o  = |vec_i;

    generate
        for (gb = 0; gb < ID_W; gb++) begin : g_enc_bit
            for (gi = 0; gi < NUM_CLIENTS; gi++) begin : g_enc_src
                assign bit_sel[gb][gi] = onehot_o[gi] & (((gi >> gb) & 1) != 0);
            end
            assign idx_o[gb] = |bit_sel[gb];
        end
    endgenerate

endmodule

// File: rtl/client_req_arbiter.sv
// N-client request arbiter with fixed/round-robin selection, per-client
// masking and a bounded hold time that forces a handover when contended.
module client_req_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_CLIENTS = 8,
    parameter  int MAX_HOLD    = 16,
    localparam int ID_W        = clog2_min1(NUM_CLIENTS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [NUM_CLIENTS-1:0] mask,
    input  logic                   mode,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic                   grant_valid,
    output logic [ID_W-1:0]        grant_id,
    output logic                   preempt
);

    localparam int                 HOLD_W   = clog2_min1(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [ID_W-1:0]    LAST_ID  = ID_W'(NUM_CLIENTS - 1);

    arb_state_e             state_q, state_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [ID_W-1:0]        rr_q, rr_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   preempt_q, preempt_d;

    logic [NUM_CLIENTS-1:0] eligible;
    logic [NUM_CLIENTS-1:0] others;
    logic                   owner_drop;
    logic                   owner_masked;
    logic                   hold_expired;
    logic [NUM_CLIENTS-1:0] pick_vec;
    logic [ID_W-1:0]        pick_start;
    logic                   pick_found;
    logic [NUM_CLIENTS-1:0] pick_onehot;
    logic [ID_W-1:0]        pick_idx;

    assign eligible     = req & ~mask;
    assign others       = eligible & ~grant_q;
    assign owner_drop   = ~|(req & grant_q);
    assign owner_masked = |(mask & grant_q);
    assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && (others != '0);

    // While granted, only competitors take part; the owner re-wins only via IDLE.
    assign pick_vec   = (state_q == ST_GRANT) ? others : eligible;
    assign pick_start = (arb_mode_e'(mode) == ARB_RR) ? rr_q : '0;

    arb_pick #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .ID_W        (ID_W)
    ) u_pick (
        .vec_i    (pick_vec),
        .start_i  (pick_start),
        .found_o  (pick_found),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        rr_d      = rr_q;
        hold_d    = hold_q;
        preempt_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_GRANT;
                    grant_d = pick_onehot;
                    id_d    = pick_idx;
                    hold_d  = HOLD_W'(1);
                    rr_d    = (pick_idx == LAST_ID) ? '0 : pick_idx + ID_W'(1);
                end
            end
            ST_GRANT: begin
                if (owner_drop || owner_masked || hold_expired) begin
                    preempt_d = hold_expired && !owner_drop && !owner_masked;
                    if (pick_found) begin
                        grant_d = pick_onehot;
                        id_d    = pick_idx;
                        hold_d  = HOLD_W'(1);
                        rr_d    = (pick_idx == LAST_ID) ? '0 : pick_idx + ID_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        id_d    = '0;
                    end
                end else if ((MAX_HOLD != 0) && (hold_q < HOLD_MAX)) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                id_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            rr_q      <= '0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            rr_q      <= rr_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_id    = id_q;
    assign preempt     = preempt_q;

endmodule

// File: tb/tb_client_req_arbiter.sv
// Scoreboard bench: the driver pushes model predictions, a monitor pops and
// compares one entry per cycle for an 8-client and a single-client arbiter.
module tb_client_req_arbiter;

    localparam int N  = 8;
    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req, mask;
    logic       mode;
    logic [7:0] grant;
    logic       gv;
    logic [2:0] gid;
    logic       pre;

    logic [0:0] req1, mask1, grant1, gid1;
    logic       gv1, pre1;

    always #5 clk = ~clk;

    client_req_arbiter #(.NUM_CLIENTS(N), .MAX_HOLD(MH)) dut (
        .clock(clk), .reset(rst), .req(req), .mask(mask), .mode(mode),
        .grant(grant), .grant_valid(gv), .grant_id(gid), .preempt(pre)
    );

    client_req_arbiter #(.NUM_CLIENTS(1), .MAX_HOLD(2)) dut1 (
        .clock(clk), .reset(rst), .req(req1), .mask(mask1), .mode(mode),
        .grant(grant1), .grant_valid(gv1), .grant_id(gid1), .preempt(pre1)
    );

    typedef struct packed {
        logic [7:0] g;
        logic [2:0] id;
        logic       p;
        logic       g1;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    // Reference state: owner index (-1 = nobody), hold count, next rr start.
    int   m_owner = -1;
    int   m_hold  = 0;
    int   m_rr    = 0;
    logic m_pre   = 1'b0;
    logic m_g1    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] v, input int start);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [7:0] el, oth;
        bit         a, b, c;
        int         w;
        if (rst) begin
            m_owner = -1; m_hold = 0; m_rr = 0; m_pre = 1'b0; m_g1 = 1'b0;
            return;
        end
        m_g1  = req1[0] & ~mask1[0];
        m_pre = 1'b0;
        el    = req & ~mask;
        if (m_owner < 0) begin
            if (el != 0) begin
                w = pick(el, mode ? m_rr : 0);
                m_owner = w; m_hold = 1; m_rr = (w + 1) % N;
            end
        end else begin
            oth = el;
            oth[m_owner] = 1'b0;
            a = !req[m_owner];
            b = mask[m_owner];
            c = (MH != 0) && (m_hold == MH) && (oth != 0);
            if (a || b || c) begin
                m_pre = c && !a && !b;
                if (oth != 0) begin
                    w = pick(oth, mode ? m_rr : 0);
                    m_owner = w; m_hold = 1; m_rr = (w + 1) % N;
                end else begin
                    m_owner = -1;
                end
            end else if (m_hold < MH) begin
                m_hold++;
            end
        end
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] mk, input logic md,
                         input logic rs, input logic r1);
        exp_t e;
        @(negedge clk);
        req = r; mask = mk; mode = md; rst = rs; req1 = r1;
        model_step();
        e.g  = (m_owner < 0) ? 8'h00 : (8'(1) << m_owner);
        e.id = (m_owner < 0) ? 3'd0 : 3'(m_owner);
        e.p  = m_pre;
        e.g1 = m_g1;
        q.push_back(e);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                txn++;
                chk("grant",       grant, e.g);
                chk("grant_id",    gid, e.id);
                chk("grant_valid", gv, |e.g);
                chk("onehot",      ($countones(grant) <= 1), 1);
                chk("preempt",     pre, e.p);
                chk("grant_n1",    grant1, e.g1);
                chk("valid_n1",    gv1, e.g1);
                chk("id_n1",       gid1, 0);
                chk("preempt_n1",  pre1, 0);
                $display("txn %0d req=%02h mask=%02h mode=%0d grant=%02h id=%0d pre=%0d g1=%0d",
                         txn, req, mask, mode, grant, gid, pre, grant1);
            end
        end
    end

    initial begin : stim
        logic [7:0] r, mk;
        rst = 1'b1; req = '0; mask = '0; mode = 1'b0; req1 = '0; mask1 = '0;

        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        after_edge();
        chk("reset_grant", grant, 8'h00);
        chk("reset_id", gid, 3'd0);

        // Fixed priority, then handover without a bubble; N=1 req 1,1,1,0,1.
        drive(8'b0001_0100, 8'h00, 1'b0, 1'b0, 1'b1);
        after_edge();
        chk("fixed_first", grant, 8'b0000_0100);
        chk("fixed_first_id", gid, 3'd2);
        drive(8'b0001_0000, 8'h00, 1'b0, 1'b0, 1'b1);
        after_edge();
        chk("handover", grant, 8'b0001_0000);
        chk("handover_id", gid, 3'd4);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

        // Round robin with everyone requesting.
        drive(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 36; i++) drive(8'hFF, 8'h00, 1'b1, 1'b0, i[0]);
        after_edge();
        chk("rr_wrap_owner", gid, 3'd0);

        // Lone owner keeps the grant past the hold limit, then is preempted.
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) drive(8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("lone_hold", grant, 8'h01);
        chk("lone_no_preempt", pre, 1'b0);
        drive(8'h21, 8'h00, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("timeout_switch", grant, 8'h20);
        chk("timeout_preempt", pre, 1'b1);
        drive(8'h21, 8'h00, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("preempt_one_cycle", pre, 1'b0);

        // Masking the owner releases it without preempt; masked request never wins.
        drive(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(8'h08, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(8'h08, 8'h08, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("mask_release", grant, 8'h00);
        chk("mask_no_preempt", pre, 1'b0);
        for (int i = 0; i < 5; i++) drive(8'h08, 8'h08, 1'b0, 1'b0, 1'b0);
        after_edge();
        chk("masked_never", grant, 8'h00);

        // Reset in the middle of a grant, then round robin from pointer 0.
        for (int i = 0; i < 3; i++) drive(8'h40, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(8'h40, 8'h00, 1'b0, 1'b1, 1'b0);
        after_edge();
        chk("midgrant_reset", grant, 8'h00);
        chk("midgrant_reset_id", gid, 3'd0);
        drive(8'h48, 8'h00, 1'b1, 1'b0, 1'b0);
        after_edge();
        chk("rr_after_reset", gid, 3'd3);
        for (int i = 0; i < 3; i++) drive(8'h48, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(8'h48, 8'h00, 1'b1, 1'b0, 1'b0);
        after_edge();
        chk("rr_second", gid, 3'd6);
        chk("rr_second_preempt", pre, 1'b1);

        // Randomised traffic with sticky requests so hold limits are exercised.
        r = 8'h00; mk = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            if ($urandom_range(0, 7) == 0) mk = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            drive(r, mk, 1'($urandom), ($urandom_range(0, 80) == 0), 1'($urandom));
        end

        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
